assoc_cache: RTL and testbench
==============================

// Module: assoc_cache
// PURPOSE
//  Parametrised 2-way set-associative, write-back, write-allocate cache for the
//  pipelined MIPS core. One instance serves IF (cpu_we tied 0) and one serves MEM.
//  It replaces fixed-cycle miss sequencing with a req/ack line interface to the
//  backing memory, and exposes one stall output to the pipeline hazard unit.
// PARAMETERS
//  ADDR_W      32  word-address width of cpu_addr
//  DATA_W      32  word width
//  SET_BITS    2   log2(number of sets)
//  OFFSET_BITS 1   log2(words per line); LINE_W = DATA_W << OFFSET_BITS
// PORTS
//  clk        in   1                  clock, rising edge
//  reset      in   1                  asynchronous, active-high
//  cpu_req    in   1                  access valid this cycle
//  cpu_we     in   1                  1 = write word, 0 = read
//  cpu_addr   in   ADDR_W             word address: {tag, set, offset}
//  cpu_wdata  in   DATA_W             write data
//  cpu_rdata  out  DATA_W             read data, valid when cpu_req & ~cpu_stall
//  cpu_stall  out  1                  hold pipeline; cpu_* must stay stable while high
//  mem_req    out  1                  line transfer request
//  mem_we     out  1                  1 = writeback, 0 = refill
//  mem_addr   out  ADDR_W-OFFSET_BITS line address
//  mem_wdata  out  LINE_W             victim line (writeback)
//  mem_rdata  in   LINE_W             refill line, sampled when mem_ack
//  mem_ack    in   1                  one-cycle completion pulse
// BEHAVIOUR
//  - Per set: 2 ways {valid, dirty, tag, line}; 1 LRU bit = way to replace next.
//  - Reset (any time, incl. mid-miss): all valid/dirty/LRU = 0, state IDLE;
//    mem_req = 0, mem_we = 0, cpu_stall = 0, cpu_rdata = 0, mem_addr/mem_wdata = 0.
//    Line data is not cleared.
//  - FSM IDLE -> {WB, REFILL}; WB -> REFILL on mem_ack; REFILL -> IDLE on mem_ack.
//  - IDLE, cpu_req = 0: no state change, cpu_stall = 0.
//  - IDLE hit: cpu_rdata is combinational, same cycle, cpu_stall = 0.
//    A write hit updates the word at the clock edge and sets dirty.
//    Every hit sets LRU = ~hit_way.
//  - IDLE miss: cpu_stall = 1 combinationally in that cycle.
//    Victim = first invalid way (way 0 first), else the LRU way.
//    Victim valid & dirty -> WB, else -> REFILL.
//  - WB: mem_req = 1, mem_we = 1, mem_addr = {victim tag, set},
//    mem_wdata = victim line, held until mem_ack.
//  - REFILL: mem_req = 1, mem_we = 0, mem_addr = cpu line address, held until mem_ack.
//    On ack: line <= mem_rdata with the write word merged if cpu_we;
//    valid = 1, dirty = cpu_we, tag installed, LRU = ~victim.
//  - The cycle after the refill ack, IDLE re-looks up, hits and drops cpu_stall.
//    Clean-miss stall = ack latency + 1; dirty miss adds the WB transfer.
//  - mem_ack outside WB/REFILL is ignored. cpu_stall = 1 in every WB/REFILL cycle.
//  - Tag compare uses the full ADDR_W-SET_BITS-OFFSET_BITS tag; no aliasing.
// CONFIGURATION
//  CACHE_STATS_EN defined:
//    - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], cleared by reset.
//    - hit_cnt increments on each IDLE hit with cpu_req.
//    - miss_cnt increments once per miss, on IDLE exit.
//    - Both saturate at 32'hFFFF_FFFF.
//  CACHE_STATS_EN undefined: no counters, no extra ports, identical timing.
// TESTING (defaults; set 0 holds addrs 0x00, 0x08, 0x10)
//  1 Read 0x10 cold -> stall, REFILL mem_addr=0x08;
//    ack with line {32'hB,32'hA} -> next cycle rdata=0xA, stall=0.
//  2 Read 0x11 after test 1 -> hit same cycle, rdata=0xB, no mem_req.
//  3 Write 0x00=0x55 (miss, refill), read 0x08 (miss, way1), read 0x10
//    -> victim way0 dirty: WB mem_addr=0x00, mem_wdata[31:0]=0x55, then REFILL 0x08.
//  4 Hold mem_ack=0 for 5 cycles in REFILL -> mem_req, mem_addr and stall stay stable.
//  5 Assert reset during WB -> mem_req=0 immediately; re-read 0x00 -> miss (valid cleared).
//  6 CACHE_STATS_EN defined, tests 1-2 -> hit_cnt=2 (incl. post-refill hit), miss_cnt=1.

Source files
------------

// File: rtl/assoc_cache_if.sv
// assoc_cache_if: CPU-side access port and memory-side line port of assoc_cache.
// The slave modport is the cache view; master is the CPU/memory environment view.
interface assoc_cache_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OFFSET_BITS = 1
);
    localparam int LINE_W = DATA_W << OFFSET_BITS;

    logic                      cpu_req;
    logic                      cpu_we;
    logic [ADDR_W-1:0]         cpu_addr;
    logic [DATA_W-1:0]         cpu_wdata;
    logic [DATA_W-1:0]         cpu_rdata;
    logic                      cpu_stall;

    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_W-OFFSET_BITS-1:0] mem_addr;
    logic [LINE_W-1:0]         mem_wdata;
    logic [LINE_W-1:0]         mem_rdata;
    logic                      mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/assoc_cache.sv
// assoc_cache: 2-way set-associative, write-back, write-allocate cache with a
// req/ack line interface to backing memory and a single stall output.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
//
// state    | meaning
// S_IDLE   | lookup; hits served combinationally, a miss starts a line transfer
// S_WB     | writing the dirty victim line back, waiting for mem_ack
// S_REFILL | fetching the requested line, waiting for mem_ack
module assoc_cache #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SET_BITS    = 2,
    parameter int OFFSET_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    assoc_cache_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int LINE_W  = DATA_W << OFFSET_BITS;
    localparam int WORDS   = 1 << OFFSET_BITS;
    localparam int SETS    = 1 << SET_BITS;
    localparam int TAG_W   = ADDR_W - SET_BITS - OFFSET_BITS;
    localparam int LADDR_W = ADDR_W - OFFSET_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;

    state_t              state_q;
    logic [SETS-1:0]     valid_q [2];
    logic [SETS-1:0]     dirty_q [2];
    logic [SETS-1:0]     lru_q;
    logic [TAG_W-1:0]    tag_q  [2][SETS];
    logic [LINE_W-1:0]   line_q [2][SETS];
    logic                victim_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [LADDR_W-1:0]  mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;

    logic [TAG_W-1:0]       addr_tag;
    logic [SET_BITS-1:0]    addr_set;
    logic [OFFSET_BITS-1:0] addr_off;
    logic [LADDR_W-1:0]     cpu_laddr;

    assign addr_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign addr_set  = bus.cpu_addr[OFFSET_BITS +: SET_BITS];
    assign addr_off  = bus.cpu_addr[OFFSET_BITS-1:0];
    assign cpu_laddr = bus.cpu_addr[ADDR_W-1:OFFSET_BITS];

    logic hit0, hit1, hit, hit_way;
    logic victim_way, victim_dirty;
    logic lookup_hit, lookup_miss, refill_done;
    logic [LINE_W-1:0] hit_line, hit_line_wr, refill_line;
    logic [DATA_W-1:0] hit_word;

    assign hit0    = valid_q[0][addr_set] && (tag_q[0][addr_set] == addr_tag);
    assign hit1    = valid_q[1][addr_set] && (tag_q[1][addr_set] == addr_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Fill an empty way before evicting anything; way 0 is preferred.
    assign victim_way   = !valid_q[0][addr_set] ? 1'b0 :
                          !valid_q[1][addr_set] ? 1'b1 : lru_q[addr_set];
    assign victim_dirty = valid_q[victim_way][addr_set] && dirty_q[victim_way][addr_set];

    assign lookup_hit  = (state_q == S_IDLE) && bus.cpu_req && hit;
    assign lookup_miss = (state_q == S_IDLE) && bus.cpu_req && !hit;
    assign refill_done = (state_q == S_REFILL) && bus.mem_ack;

    assign hit_line = line_q[hit_way][addr_set];

    // Word select for reads and word merge for write hits and write-allocate refills.
    always_comb begin
        hit_word    = '0;
        hit_line_wr = hit_line;
        refill_line = bus.mem_rdata;
        for (int w = 0; w < WORDS; w++) begin
            if (addr_off == OFFSET_BITS'(w)) begin
                hit_word = hit_line[w*DATA_W +: DATA_W];
                hit_line_wr[w*DATA_W +: DATA_W] = bus.cpu_wdata;
                if (bus.cpu_we) begin
                    refill_line[w*DATA_W +: DATA_W] = bus.cpu_wdata;
                end
            end
        end
    end

    // Stall is held low while reset is asserted, even with a request pending.
    assign bus.cpu_rdata = lookup_hit ? hit_word : '0;
    assign bus.cpu_stall = !reset && ((state_q != S_IDLE) || lookup_miss);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Miss sequencing FSM with registered memory-side outputs and line metadata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            dirty_q[0]  <= '0;
            dirty_q[1]  <= '0;
            lru_q       <= '0;
            victim_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        if (hit) begin
                            lru_q[addr_set] <= ~hit_way;
                            if (bus.cpu_we) begin
                                dirty_q[hit_way][addr_set] <= 1'b1;
                            end
                        end else begin
                            victim_q  <= victim_way;
                            mem_req_q <= 1'b1;
                            if (victim_dirty) begin
                                state_q     <= S_WB;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= {tag_q[victim_way][addr_set], addr_set};
                                mem_wdata_q <= line_q[victim_way][addr_set];
                            end else begin
                                state_q    <= S_REFILL;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= cpu_laddr;
                            end
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_ack) begin
                        state_q    <= S_REFILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= cpu_laddr;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ack) begin
                        state_q                     <= S_IDLE;
                        mem_req_q                   <= 1'b0;
                        valid_q[victim_q][addr_set] <= 1'b1;
                        dirty_q[victim_q][addr_set] <= bus.cpu_we;
                        lru_q[addr_set]             <= ~victim_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line data and tags are not reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (lookup_hit && bus.cpu_we) begin
            line_q[hit_way][addr_set] <= hit_line_wr;
        end
        if (refill_done) begin
            line_q[victim_q][addr_set] <= refill_line;
            tag_q[victim_q][addr_set]  <= addr_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit/miss counters; a miss is counted once as the FSM leaves IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (lookup_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed vector table, hand-written miss/reset sequences and
// a randomized run against a recency-ordered reference model of assoc_cache.
module tb_assoc_cache;
    logic clk;
    logic reset;

    assoc_cache_if #(.ADDR_W(32), .DATA_W(32), .OFFSET_BITS(1)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    assoc_cache #(.ADDR_W(32), .DATA_W(32), .SET_BITS(2), .OFFSET_BITS(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [30:0] laddr;
        logic [63:0] data;
    } txn_t;

    typedef struct {
        logic [30:0] laddr;
        logic        dirty;
        logic [63:0] data;
    } mline_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_stall;
        int          exp_ntxn;
        logic        exp_wb;
        logic [30:0] wb_addr;
        logic [63:0] wb_data;
        logic [30:0] rf_addr;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    txn_t        obs_q[$];
    txn_t        exp_q[$];
    logic [63:0] env_mem [logic [30:0]];
    logic [63:0] ref_mem [logic [30:0]];
    mline_t      mset [4][$];

    function automatic logic [63:0] line_init(logic [30:0] la);
        logic [31:0] w0, w1;
        w0 = 32'hD000_0000 ^ {la, 1'b0};
        w1 = 32'hD000_0000 ^ {la, 1'b1};
        return {w1, w0};
    endfunction

    function automatic logic [63:0] env_rd(logic [30:0] la);
        if (env_mem.exists(la)) return env_mem[la];
        return line_init(la);
    endfunction

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wd, int lat,
                                logic chk, logic [31:0] erd, int est, int ntx,
                                logic ewb, logic [30:0] wba, logic [63:0] wbd, logic [30:0] rfa);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.lat = lat;
        v.chk_rd = chk; v.exp_rd = erd; v.exp_stall = est; v.exp_ntxn = ntx;
        v.exp_wb = ewb; v.wb_addr = wba; v.wb_data = wbd; v.rf_addr = rfa;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One CPU access from a negedge; serves memory transfers after 'lat' waiting cycles.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input int lat, output logic [31:0] rd, output int stalls,
                              output logic to);
        int waited;
        waited = 0;
        stalls = 0;
        to     = 1'b0;
        obs_q.delete();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        #1;
        while (bus.cpu_stall && !to) begin
            if (bus.mem_req) begin
                if (waited >= lat) begin
                    obs_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
                    if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = env_rd(bus.mem_addr);
                    bus.mem_ack = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            #1;
            stalls++;
            if (stalls > 100) to = 1'b1;
        end
        rd = bus.cpu_rdata;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    // Reference model: per set, resident lines in most-recent-first order.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input int lat, output logic [31:0] exp_rd, output int exp_stall);
        logic [30:0] la;
        int          s;
        int          idx;
        logic        wb;
        mline_t      e;
        la  = addr[31:1];
        s   = int'(la[1:0]);
        idx = -1;
        wb  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < mset[s].size(); i++) begin
            if (mset[s][i].laddr == la) idx = i;
        end
        if (idx >= 0) begin
            e = mset[s][idx];
            mset[s].delete(idx);
            exp_stall = 0;
        end else begin
            if (mset[s].size() == 2) begin
                mline_t v;
                v = mset[s].pop_back();
                if (v.dirty) begin
                    exp_q.push_back('{1'b1, v.laddr, v.data});
                    ref_mem[v.laddr] = v.data;
                    wb = 1'b1;
                end
            end
            e.laddr = la;
            e.dirty = 1'b0;
            e.data  = ref_mem.exists(la) ? ref_mem[la] : line_init(la);
            exp_q.push_back('{1'b0, la, 64'h0});
            exp_stall = 1 + (wb ? lat + 1 : 0) + lat + 1;
        end
        if (we) begin
            if (addr[0]) e.data[63:32] = wd;
            else         e.data[31:0]  = wd;
            e.dirty = 1'b1;
        end
        exp_rd = addr[0] ? e.data[63:32] : e.data[31:0];
        mset[s].push_front(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vec [9];
        logic [31:0] rd, erd, a, wd;
        int          stalls, es, lat, n_miss;
        logic        to, we;

        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        vec[0] = mk(0, 32'h10, 0,      0, 1, 32'hA,         2, 1, 0, 0, 0, 31'h08);
        vec[1] = mk(0, 32'h11, 0,      0, 1, 32'hB,         0, 0, 0, 0, 0, 0);
        vec[2] = mk(1, 32'h00, 32'h55, 1, 0, 0,             3, 1, 0, 0, 0, 31'h00);
        vec[3] = mk(0, 32'h08, 0,      2, 1, 32'hD000_0008, 4, 1, 0, 0, 0, 31'h04);
        vec[4] = mk(0, 32'h10, 0,      1, 1, 32'hA,         5, 2, 1, 31'h00,
                    {32'hD000_0001, 32'h55}, 31'h08);
        vec[5] = mk(0, 32'h01, 0,      0, 1, 32'hD000_0001, 2, 1, 0, 0, 0, 31'h00);
        vec[6] = mk(0, 32'h00, 0,      0, 1, 32'h55,        0, 0, 0, 0, 0, 0);
        vec[7] = mk(1, 32'h21, 32'h77, 0, 0, 0,             2, 1, 0, 0, 0, 31'h10);
        vec[8] = mk(0, 32'h21, 0,      0, 1, 32'h77,        0, 0, 0, 0, 0, 0);

        env_mem[31'h08] = {32'hB, 32'hA};

        // Reset state, with a request pending to show the stall is held low.
        #2;
        reset        = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h10;
        #1;
        check("rst_stall",     64'(bus.cpu_stall), 64'(0));
        check("rst_mem_req",   64'(bus.mem_req),   64'(0));
        check("rst_mem_we",    64'(bus.mem_we),    64'(0));
        check("rst_rdata",     64'(bus.cpu_rdata), 64'(0));
        check("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
        check("rst_mem_wdata", bus.mem_wdata,      64'(0));
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        bus.cpu_req = 1'b0;

        // Directed vectors.
        n_miss = 0;
        for (int i = 0; i < 9; i++) begin
            run_access(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].lat, rd, stalls, to);
            if (vec[i].exp_stall != 0) n_miss++;
            check($sformatf("v%0d_timeout", i), 64'(to), 64'(0));
            check($sformatf("v%0d_stall", i), 64'(stalls), 64'(vec[i].exp_stall));
            if (vec[i].chk_rd) check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vec[i].exp_rd));
            check($sformatf("v%0d_ntxn", i), 64'(obs_q.size()), 64'(vec[i].exp_ntxn));
            if (vec[i].exp_wb && obs_q.size() > 0) begin
                check($sformatf("v%0d_wb_we", i),   64'(obs_q[0].we),    64'(1));
                check($sformatf("v%0d_wb_addr", i), 64'(obs_q[0].laddr), 64'(vec[i].wb_addr));
                check($sformatf("v%0d_wb_data", i), obs_q[0].data,       vec[i].wb_data);
            end
            if (vec[i].exp_ntxn > 0 && obs_q.size() > 0) begin
                check($sformatf("v%0d_rf_we", i),   64'(obs_q[obs_q.size()-1].we),    64'(0));
                check($sformatf("v%0d_rf_addr", i), 64'(obs_q[obs_q.size()-1].laddr), 64'(vec[i].rf_addr));
            end
        end
`ifdef CACHE_STATS_EN
        check("stat_hits", 64'(hit_cnt),  64'(9));
        check("stat_miss", 64'(miss_cnt), 64'(n_miss));
`endif

        // Refill held without ack: request, address and stall must not move.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h02;
        #1;
        check("hold_miss_stall", 64'(bus.cpu_stall), 64'(1));
        check("hold_idle_req",   64'(bus.mem_req),   64'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold%0d_stall", i), 64'(bus.cpu_stall), 64'(1));
            check($sformatf("hold%0d_req", i),   64'(bus.mem_req),   64'(1));
            check($sformatf("hold%0d_we", i),    64'(bus.mem_we),    64'(0));
            check($sformatf("hold%0d_addr", i),  64'(bus.mem_addr),  64'(1));
        end
        bus.mem_rdata = {32'h22, 32'h11};
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check("hold_done_stall", 64'(bus.cpu_stall), 64'(0));
        check("hold_done_rdata", 64'(bus.cpu_rdata), 64'(32'h11));
        @(negedge clk);
        bus.cpu_req = 1'b0;

        // Reset in the middle of a writeback.
        run_access(1, 32'h06, 32'h99, 0, rd, stalls, to);
        check("wbr_w1_stall", 64'(stalls), 64'(2));
        run_access(1, 32'h0E, 32'h98, 0, rd, stalls, to);
        check("wbr_w2_stall", 64'(stalls), 64'(2));
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h16;
        #1;
        check("wbr_miss_stall", 64'(bus.cpu_stall), 64'(1));
        @(negedge clk);
        #1;
        check("wbr_req",   64'(bus.mem_req),  64'(1));
        check("wbr_we",    64'(bus.mem_we),   64'(1));
        check("wbr_addr",  64'(bus.mem_addr), 64'(3));
        check("wbr_wdata", bus.mem_wdata,     {32'hD000_0007, 32'h99});
        #1;
        reset = 1'b1;
        #1;
        check("wbr_rst_req",   64'(bus.mem_req),   64'(0));
        check("wbr_rst_we",    64'(bus.mem_we),    64'(0));
        check("wbr_rst_stall", 64'(bus.cpu_stall), 64'(0));
        check("wbr_rst_addr",  64'(bus.mem_addr),  64'(0));
        @(negedge clk);
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        run_access(0, 32'h06, 0, 0, rd, stalls, to);
        check("wbr_reread_stall", 64'(stalls), 64'(2));
        check("wbr_reread_ntxn",  64'(obs_q.size()), 64'(1));
        if (obs_q.size() == 1) begin
            check("wbr_reread_we",   64'(obs_q[0].we),    64'(0));
            check("wbr_reread_addr", 64'(obs_q[0].laddr), 64'(3));
        end
        check("wbr_reread_rdata", 64'(rd), 64'(32'hD000_0006));

        // Randomized accesses against the reference model.
        do_reset();
        env_mem.delete();
        ref_mem.delete();
        for (int s = 0; s < 4; s++) mset[s].delete();
        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
            wd  = $urandom;
            lat = $urandom_range(0, 3);
            model_access(we, a, wd, lat, erd, es);
            run_access(we, a, wd, lat, rd, stalls, to);
            check("rnd_timeout", 64'(to), 64'(0));
            check("rnd_stall", 64'(stalls), 64'(es));
            if (!we) check("rnd_rdata", 64'(rd), 64'(erd));
            check("rnd_ntxn", 64'(obs_q.size()), 64'(exp_q.size()));
            if (obs_q.size() == exp_q.size()) begin
                for (int i = 0; i < obs_q.size(); i++) begin
                    check("rnd_txn_we",   64'(obs_q[i].we),    64'(exp_q[i].we));
                    check("rnd_txn_addr", 64'(obs_q[i].laddr), 64'(exp_q[i].laddr));
                    if (exp_q[i].we) check("rnd_txn_data", obs_q[i].data, exp_q[i].data);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
